// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FSM state encoding, data word width and the
// error-cause codes that the datapath also decodes.
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

    // Misalignment is reported in preference to range when both apply.
    function automatic logic [1:0] err_cause(input logic misaligned, input logic out_of_range);
        if (misaligned)
            return ERR_MISALIGN;
        else if (out_of_range)
            return ERR_RANGE;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word-wide data storage: one shared address, synchronous write with enable,
// registered read with enable. Contents are never reset.
module dmem_word_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[addr] <= wdata;
        if (rd_en)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request at a time, inserts WAIT_CYCLES
// wait states, performs the word access and returns a one-cycle response.
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int          IDX_W     = ADDR_W - 2;
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic                rd_ok_reg;
    logic                err_reg;

    logic [IDX_W-1:0]    idx;
    logic [31:0]         idx_ext;
    logic [1:0]          cause;
    logic                acc_err;
    logic                in_access;
    logic                mem_wr_en;
    logic                mem_rd_en;
    logic [WORD_W-1:0]   mem_rdata;

    // Range check on the zero-extended index so an index of exactly DEPTH
    // (or beyond) never wraps onto a valid word.
    assign idx       = addr_reg[ADDR_W-1:2];
    assign idx_ext   = {{(32-IDX_W){1'b0}}, idx};
    assign cause     = err_cause(addr_reg[1:0] != 2'b00, idx_ext >= 32'(DEPTH));
    assign acc_err   = (cause != ERR_NONE);
    assign in_access = (state_reg == ST_ACCESS);
    assign mem_wr_en = in_access && we_reg && !acc_err && !RST;
    assign mem_rd_en = in_access && !we_reg && !acc_err;

    dmem_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .wr_en (mem_wr_en),
        .rd_en (mem_rd_en),
        .addr  (idx[AW-1:0]),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_next   = WAIT_INIT;
                    state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1)
                    state_next = ST_ACCESS;
            end
            ST_ACCESS: state_next = ST_RESP;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rd_ok_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ST_IDLE && req_valid) begin
                we_reg    <= req_we;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (in_access) begin
                rd_ok_reg <= mem_rd_en;
                err_reg   <= acc_err;
            end
        end
    end

    // The array's read register only updates on good reads, so masking it
    // with rd_ok_reg yields 0 for writes/errors and holds between responses.
    assign resp_rdata = rd_ok_reg ? mem_rdata : '0;
    assign resp_err   = err_reg;
    assign resp_valid = (state_reg == ST_RESP);
    assign req_ready  = (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);

endmodule
